fetch_stage: RTL and testbench

Instruction-fetch stage that sits directly upstream of the decode stage. It owns the PC register and next-PC selection, and drives a request/ready handshake to a multi-cycle instruction memory. It produces the IF/ID pipeline register contents (pc, instruction, valid). It honours stall from the hazard unit and flush/redirect from branch resolution.

---
 rtl/cpu_pkg.sv | 16 +
 rtl/if_id_reg.sv | 46 ++++
 rtl/fetch_stage.sv | 162 ++++++++++++++++
 tb/tb_fetch_stage.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width, reset PC, bubble instruction and
// the fetch-stage state encoding. Imported by the fetch stage and the
// pipeline registers.
package cpu_pkg;

  localparam int          CPU_XLEN      = 32;
  localparam logic [31:0] CPU_RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] CPU_NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// Generic pipeline register holding {pc, instruction, valid}.
// Control priority: bubble (flush) > hold (stall) > load > keep.
module if_id_reg import cpu_pkg::*; #(
  parameter int          XLEN      = CPU_XLEN,
  parameter logic [31:0] NOP_INSTR = CPU_NOP_INSTR
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_bubble,
  input  logic            i_hold,
  input  logic            i_load,
  input  logic [XLEN-1:0] i_pc,
  input  logic [31:0]     i_instr,
  output logic [XLEN-1:0] o_pc,
  output logic [31:0]     o_instr,
  output logic            o_valid
);

  logic [XLEN-1:0] r_pc;
  logic [31:0]     r_instr;
  logic            r_valid;

  // Register update: a bubble wins over a stall, a stall freezes the contents,
  // otherwise a load captures a real instruction; with no control it keeps.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pc    <= '0;
      r_instr <= NOP_INSTR;
      r_valid <= 1'b0;
    end else if (i_bubble) begin
      r_instr <= NOP_INSTR;
      r_valid <= 1'b0;
    end else if (i_hold) begin
      r_pc    <= r_pc;
    end else if (i_load) begin
      r_pc    <= i_pc;
      r_instr <= i_instr;
      r_valid <= 1'b1;
    end
  end

  assign o_pc    = r_pc;
  assign o_instr = r_instr;
  assign o_valid = r_valid;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC selection, request/ready
// handshake to a multi-cycle instruction memory and the IF/ID register.
// Optional performance counters are enabled by defining FETCH_PERF_EN.
module fetch_stage import cpu_pkg::*; #(
  parameter int              XLEN      = CPU_XLEN,
  parameter logic [XLEN-1:0] RESET_PC  = XLEN'(CPU_RESET_PC),
  parameter logic [31:0]     NOP_INSTR = CPU_NOP_INSTR
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] branch_target_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_ready_i,
  input  logic [31:0]     imem_rdata_i,
`ifdef FETCH_PERF_EN
  output logic [31:0]     perf_fetched_o,
  output logic [31:0]     perf_wait_o,
`endif
  output logic [XLEN-1:0] pc_o,
  output logic [31:0]     instr_o,
  output logic            valid_o
);

  fetch_state_e    r_state;
  logic [XLEN-1:0] r_pc;
  logic            r_redirPending;
  logic [XLEN-1:0] r_redirPc;
  logic [XLEN-1:0] r_skidPc;
  logic [31:0]     r_skidInstr;

  fetch_state_e    w_stateNext;
  logic [XLEN-1:0] w_pcNext;
  logic            w_pendNext;
  logic [XLEN-1:0] w_redirPcNext;
  logic            w_skidCapture;
  logic            w_ifBubble;
  logic            w_ifLoad;
  logic [XLEN-1:0] w_ifPc;
  logic [31:0]     w_ifInstr;
  logic [XLEN-1:0] w_target;
  logic [XLEN-1:0] w_pcPlus4;

  assign w_target  = {branch_target_i[XLEN-1:2], 2'b00};
  assign w_pcPlus4 = r_pc + XLEN'(4);

  // The address always mirrors the PC, so it stays put while a request waits.
  assign imem_req_o  = (r_state == FETCH);
  assign imem_addr_o = r_pc;

  // Next-state and IF/ID control: a redirect (live or pending) wins over a
  // stall, a stall on returning data parks it in the skid buffer.
  always_comb begin
    w_stateNext   = r_state;
    w_pcNext      = r_pc;
    w_pendNext    = r_redirPending;
    w_redirPcNext = r_redirPc;
    w_skidCapture = 1'b0;
    w_ifBubble    = 1'b0;
    w_ifLoad      = 1'b0;
    w_ifPc        = r_pc;
    w_ifInstr     = imem_rdata_i;
    case (r_state)
      IDLE: begin
        if (start_i) w_stateNext = FETCH;
      end
      FETCH: begin
        if (!imem_ready_i) begin
          if (flush_i) begin
            w_pendNext    = 1'b1;
            w_redirPcNext = w_target;
          end
          w_ifBubble = flush_i || !stall_i;
        end else if (r_redirPending || flush_i) begin
          w_pcNext   = flush_i ? w_target : r_redirPc;
          w_pendNext = 1'b0;
          w_ifBubble = 1'b1;
        end else if (stall_i) begin
          w_skidCapture = 1'b1;
          w_stateNext   = HOLD;
        end else begin
          w_ifLoad = 1'b1;
          w_pcNext = w_pcPlus4;
        end
      end
      HOLD: begin
        if (flush_i) begin
          w_pcNext    = w_target;
          w_ifBubble  = 1'b1;
          w_stateNext = FETCH;
        end else if (!stall_i) begin
          w_ifLoad    = 1'b1;
          w_ifPc      = r_skidPc;
          w_ifInstr   = r_skidInstr;
          w_pcNext    = w_pcPlus4;
          w_stateNext = FETCH;
        end
      end
      default: w_stateNext = IDLE;
    endcase
  end

  // State, PC, pending redirect and skid buffer registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state        <= IDLE;
      r_pc           <= RESET_PC;
      r_redirPending <= 1'b0;
      r_redirPc      <= RESET_PC;
      r_skidPc       <= '0;
      r_skidInstr    <= NOP_INSTR;
    end else begin
      r_state        <= w_stateNext;
      r_pc           <= w_pcNext;
      r_redirPending <= w_pendNext;
      r_redirPc      <= w_redirPcNext;
      if (w_skidCapture) begin
        r_skidPc    <= r_pc;
        r_skidInstr <= imem_rdata_i;
      end
    end
  end

  if_id_reg #(
    .XLEN      (XLEN),
    .NOP_INSTR (NOP_INSTR)
  ) u_ifId (
    .i_clk    (clk_i),
    .i_rst    (rst_i),
    .i_bubble (w_ifBubble),
    .i_hold   (stall_i),
    .i_load   (w_ifLoad),
    .i_pc     (w_ifPc),
    .i_instr  (w_ifInstr),
    .o_pc     (pc_o),
    .o_instr  (instr_o),
    .o_valid  (valid_o)
  );

`ifdef FETCH_PERF_EN
  logic [31:0] r_perfFetched;
  logic [31:0] r_perfWait;

  // Counts real instructions entering IF/ID and cycles spent waiting on memory.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_perfFetched <= '0;
      r_perfWait    <= '0;
    end else begin
      if (w_ifLoad && !w_ifBubble && !stall_i) r_perfFetched <= r_perfFetched + 32'd1;
      if (r_state == FETCH && !imem_ready_i)   r_perfWait    <= r_perfWait + 32'd1;
    end
  end

  assign perf_fetched_o = r_perfFetched;
  assign perf_wait_o    = r_perfWait;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a scoreboard of expected IF/ID loads.
// Builds with or without FETCH_PERF_EN.
module tb_fetch_stage;
  import cpu_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic        stall_i;
  logic        flush_i;
  logic [31:0] branch_target_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ready_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] pc_o;
  logic [31:0] instr_o;
  logic        valid_o;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_o;
  logic [31:0] perf_wait_o;
`endif

  int checks = 0;
  int errors = 0;
  logic [63:0] sbQueue[$];

  always #5 clk_i = ~clk_i;

  // Instruction memory contents as seen by the bench.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    case (a)
      32'h0: memWord = 32'h0050_0093;
      32'h4: memWord = 32'h00A0_0113;
      default: memWord = {a[15:0], 16'h0093};
    endcase
  endfunction

  assign imem_rdata_i = memWord(imem_addr_o);

  fetch_stage dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .start_i         (start_i),
    .stall_i         (stall_i),
    .flush_i         (flush_i),
    .branch_target_i (branch_target_i),
    .imem_req_o      (imem_req_o),
    .imem_addr_o     (imem_addr_o),
    .imem_ready_i    (imem_ready_i),
    .imem_rdata_i    (imem_rdata_i),
`ifdef FETCH_PERF_EN
    .perf_fetched_o  (perf_fetched_o),
    .perf_wait_o     (perf_wait_o),
`endif
    .pc_o            (pc_o),
    .instr_o         (instr_o),
    .valid_o         (valid_o)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic applyStimulus(input logic st, input logic sl, input logic fl,
                               input logic [31:0] tgt, input logic rdy);
    start_i         = st;
    stall_i         = sl;
    flush_i         = fl;
    branch_target_i = tgt;
    imem_ready_i    = rdy;
  endtask

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic expectLoad(input logic [31:0] pc);
    sbQueue.push_back({pc, memWord(pc)});
  endtask

  task automatic checkBubble(input string tag);
    checkEq({tag, "_valid"}, {31'd0, valid_o}, 32'd0);
    checkEq({tag, "_instr"}, instr_o, NOP);
  endtask

  // Pops the oldest expected load and compares it against IF/ID.
  task automatic checkOutput(input string tag);
    logic [63:0] e;
    if (sbQueue.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s scoreboard empty observed pc=%h", tag, pc_o);
    end else begin
      e = sbQueue.pop_front();
      checkEq({tag, "_pc"}, pc_o, e[63:32]);
      checkEq({tag, "_instr"}, instr_o, e[31:0]);
      checkEq({tag, "_valid"}, {31'd0, valid_o}, 32'd1);
    end
  endtask

  initial begin
    rst_i = 1'b1;
    applyStimulus(0, 0, 0, 32'h0, 0);
    tick();
    tick();
    checkEq("rst_req", {31'd0, imem_req_o}, 32'd0);
    checkEq("rst_addr", imem_addr_o, 32'h0);
    checkEq("rst_pc", pc_o, 32'h0);
    checkBubble("rst");

    // Back-to-back fetch with an always-ready memory.
    rst_i = 1'b0;
    applyStimulus(1, 0, 0, 32'h0, 1);
    tick();
    checkEq("start_req", {31'd0, imem_req_o}, 32'd1);
    checkEq("start_addr", imem_addr_o, 32'h0);
    applyStimulus(0, 0, 0, 32'h0, 1);
    expectLoad(32'h0);
    tick();
    checkOutput("seq0");
    checkEq("seq0_addr", imem_addr_o, 32'h4);
    expectLoad(32'h4);
    tick();
    checkOutput("seq4");
    checkEq("seq4_addr", imem_addr_o, 32'h8);

    // Two-cycle stall on a ready fetch at 0x8.
    applyStimulus(0, 1, 0, 32'h0, 1);
    tick();
    checkEq("hold1_pc", pc_o, 32'h4);
    checkEq("hold1_req", {31'd0, imem_req_o}, 32'd0);
    tick();
    checkEq("hold2_pc", pc_o, 32'h4);
    checkEq("hold2_req", {31'd0, imem_req_o}, 32'd0);
    applyStimulus(0, 0, 0, 32'h0, 1);
    expectLoad(32'h8);
    tick();
    checkOutput("release8");
    checkEq("release_addr", imem_addr_o, 32'hC);
    checkEq("release_req", {31'd0, imem_req_o}, 32'd1);

    // Three wait cycles at 0xC.
    applyStimulus(0, 0, 0, 32'h0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkEq("wait_addr", imem_addr_o, 32'hC);
      checkEq("wait_req", {31'd0, imem_req_o}, 32'd1);
      checkBubble("wait");
    end
    applyStimulus(0, 0, 0, 32'h0, 1);
    expectLoad(32'hC);
    tick();
    checkOutput("waitC");
    checkEq("waitC_addr", imem_addr_o, 32'h10);
`ifdef FETCH_PERF_EN
    checkEq("perf_wait", perf_wait_o, 32'd3);
    checkEq("perf_fetched", perf_fetched_o, 32'd4);
`endif

    // Flush while the request at 0x10 waits.
    applyStimulus(0, 0, 1, 32'h40, 0);
    tick();
    checkBubble("flushw");
    checkEq("flushw_addr", imem_addr_o, 32'h10);
    applyStimulus(0, 0, 0, 32'h0, 0);
    tick();
    checkEq("flushw2_addr", imem_addr_o, 32'h10);
    applyStimulus(0, 0, 0, 32'h0, 1);
    tick();
    checkBubble("flushdrop");
    checkEq("flushdrop_addr", imem_addr_o, 32'h40);
    expectLoad(32'h40);
    tick();
    checkOutput("tgt40");
    checkEq("tgt40_addr", imem_addr_o, 32'h44);

    // Flush and stall together; target low bits forced to zero.
    applyStimulus(0, 1, 1, 32'h103, 1);
    tick();
    checkBubble("flstall");
    checkEq("flstall_addr", imem_addr_o, 32'h100);
    checkEq("flstall_req", {31'd0, imem_req_o}, 32'd1);
    applyStimulus(0, 1, 0, 32'h0, 1);
    tick();
    checkEq("holdB_req", {31'd0, imem_req_o}, 32'd0);
    applyStimulus(0, 1, 1, 32'h203, 1);
    tick();
    checkBubble("holdflush");
    checkEq("holdflush_addr", imem_addr_o, 32'h200);
    checkEq("holdflush_req", {31'd0, imem_req_o}, 32'd1);
    applyStimulus(0, 0, 0, 32'h0, 1);
    expectLoad(32'h200);
    tick();
    checkOutput("tgt200");

    // Reset during a wait, flush ignored in IDLE, restart from 0.
    applyStimulus(0, 0, 0, 32'h0, 0);
    tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    checkEq("rstmid_req", {31'd0, imem_req_o}, 32'd0);
    checkEq("rstmid_addr", imem_addr_o, 32'h0);
    checkBubble("rstmid");
    applyStimulus(0, 0, 1, 32'h80, 1);
    tick();
    checkEq("idleflush_req", {31'd0, imem_req_o}, 32'd0);
    checkEq("idleflush_addr", imem_addr_o, 32'h0);
    applyStimulus(1, 0, 0, 32'h0, 1);
    tick();
    checkEq("restart_addr", imem_addr_o, 32'h0);
    applyStimulus(0, 0, 0, 32'h0, 1);
    expectLoad(32'h0);
    tick();
    checkOutput("restart0");

    // PC wrap-around at the top of the address space.
    applyStimulus(0, 0, 1, 32'hFFFF_FFFF, 1);
    tick();
    checkEq("wrap_addr", imem_addr_o, 32'hFFFF_FFFC);
    applyStimulus(0, 0, 0, 32'h0, 1);
    expectLoad(32'hFFFF_FFFC);
    tick();
    checkOutput("wrapload");
    checkEq("wrap_next", imem_addr_o, 32'h0);
`ifdef FETCH_PERF_EN
    checkEq("perf_fetched_end", perf_fetched_o, 32'd2);
    checkEq("perf_wait_end", perf_wait_o, 32'd0);
`endif

    checks++;
    assert (sbQueue.size() == 0) else begin
      errors++;
      $error("[TB] FAIL sb_leftover observed=%0d expected=0", sbQueue.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
